// File: rtl/lcd_write_ctrl.sv
// HD44780-style LCD write controller: runs the power-up init sequence, then turns
// each accepted byte into a timed SETUP/PULSE/HOLD/WAIT write cycle on the LCD pins.
module lcd_write_ctrl #(
    parameter int T_POWERUP = 750000,
    parameter int T_SETUP   = 3,
    parameter int T_PULSE   = 12,
    parameter int T_HOLD    = 3,
    parameter int T_EXEC    = 2000,
    parameter int T_CLEAR   = 82000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_valid,
    input  logic       i_rs,
    input  logic [7:0] i_data,
    input  logic       i_lcd_on,
    output logic       o_ready,
    output logic       o_init_done,
    output logic       o_lcd_en,
    output logic       o_lcd_rs,
    output logic       o_lcd_rw,
    output logic [7:0] o_lcd_data,
    output logic       o_lcd_on
);

    localparam int T_MAX = (T_POWERUP > T_CLEAR) ? T_POWERUP : T_CLEAR;
    localparam int CNT_W = $clog2(T_MAX + 1);

    localparam logic [2:0] S_PWRUP = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_PULSE = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_WAIT  = 3'd4;
    localparam logic [2:0] S_IDLE  = 3'd5;

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       init_idx;
    logic             is_clear;

    function automatic logic [7:0] init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] load(input int t);
        return CNT_W'(t - 1);
    endfunction

    // Clear display (0x01) and return home (0x02/0x03) need the long execution wait.
    assign is_clear = !o_lcd_rs && (o_lcd_data[7:2] == 6'd0) && (o_lcd_data != 8'd0);

    assign o_lcd_rw = 1'b0;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state       <= S_PWRUP;
            cnt         <= '0;
            init_idx    <= 2'd0;
            o_ready     <= 1'b0;
            o_init_done <= 1'b0;
            o_lcd_en    <= 1'b0;
            o_lcd_rs    <= 1'b0;
            o_lcd_data  <= 8'd0;
            o_lcd_on    <= 1'b0;
        end else begin
            o_lcd_on <= i_lcd_on;
            case (state)
                // Counter starts at 0 out of reset, so power-up counts upward.
                S_PWRUP: begin
                    if (cnt == load(T_POWERUP)) begin
                        state      <= S_SETUP;
                        cnt        <= load(T_SETUP);
                        init_idx   <= 2'd0;
                        o_lcd_rs   <= 1'b0;
                        o_lcd_data <= init_cmd(2'd0);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_SETUP: begin
                    if (cnt == '0) begin
                        state    <= S_PULSE;
                        cnt      <= load(T_PULSE);
                        o_lcd_en <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_PULSE: begin
                    if (cnt == '0) begin
                        state    <= S_HOLD;
                        cnt      <= load(T_HOLD);
                        o_lcd_en <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_HOLD: begin
                    if (cnt == '0) begin
                        state <= S_WAIT;
                        cnt   <= is_clear ? load(T_CLEAR) : load(T_EXEC);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_WAIT: begin
                    if (cnt == '0) begin
                        if (!o_init_done && (init_idx != 2'd3)) begin
                            state      <= S_SETUP;
                            cnt        <= load(T_SETUP);
                            init_idx   <= init_idx + 2'd1;
                            o_lcd_data <= init_cmd(init_idx + 2'd1);
                        end else begin
                            state       <= S_IDLE;
                            o_ready     <= 1'b1;
                            o_init_done <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_IDLE: begin
                    if (i_valid) begin
                        state      <= S_SETUP;
                        cnt        <= load(T_SETUP);
                        o_ready    <= 1'b0;
                        o_lcd_rs   <= i_rs;
                        o_lcd_data <= i_data;
                    end
                end
                default: begin
                    state    <= S_PWRUP;
                    cnt      <= '0;
                    o_ready  <= 1'b0;
                    o_lcd_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_write_ctrl.sv
// Directed self-checking bench for lcd_write_ctrl using shortened timing parameters.
module tb_lcd_write_ctrl;

    logic       clk;
    logic       reset_n;
    logic       valid;
    logic       rs;
    logic [7:0] data;
    logic       lcd_on_in;
    logic       ready;
    logic       init_done;
    logic       lcd_en;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [7:0] lcd_data;
    logic       lcd_on;

    int errors = 0;
    int checks = 0;

    // Results of the init-sequence monitor
    int         npulse;
    logic [7:0] pd [4];
    int         pw [4];
    logic       rs_bad;
    logic       rw_bad;
    int         rdy_cyc;
    int         done_cyc;

    lcd_write_ctrl #(
        .T_POWERUP(20),
        .T_SETUP  (2),
        .T_PULSE  (4),
        .T_HOLD   (2),
        .T_EXEC   (10),
        .T_CLEAR  (30)
    ) dut (
        .i_clk      (clk),
        .i_reset    (reset_n),
        .i_valid    (valid),
        .i_rs       (rs),
        .i_data     (data),
        .i_lcd_on   (lcd_on_in),
        .o_ready    (ready),
        .o_init_done(init_done),
        .o_lcd_en   (lcd_en),
        .o_lcd_rs   (lcd_rs),
        .o_lcd_rw   (lcd_rw),
        .o_lcd_data (lcd_data),
        .o_lcd_on   (lcd_on)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 300 && !ready; i++) tick();
        if (!ready) begin
            checks++;
            errors++;
            $display("FAIL wait_ready: ready=%b required=1 within 300 cycles", ready);
        end
    endtask

    // Releases reset and records EN pulses until ready and init_done are both seen.
    task automatic run_init();
        logic prev_en;
        prev_en  = 1'b0;
        npulse   = 0;
        rs_bad   = 1'b0;
        rw_bad   = 1'b0;
        rdy_cyc  = -1;
        done_cyc = -1;
        for (int i = 0; i < 4; i++) begin
            pd[i] = 8'd0;
            pw[i] = 0;
        end
        reset_n = 1'b1;
        for (int n = 1; n <= 300; n++) begin
            tick();
            if (lcd_en && !prev_en) begin
                if (npulse < 4) pd[npulse] = lcd_data;
                npulse++;
            end
            if (lcd_en && npulse >= 1 && npulse <= 4) pw[npulse-1]++;
            if (lcd_en && lcd_rs) rs_bad = 1'b1;
            if (lcd_rw) rw_bad = 1'b1;
            if (init_done && done_cyc < 0) done_cyc = n;
            if (ready && rdy_cyc < 0) rdy_cyc = n;
            prev_en = lcd_en;
            if (rdy_cyc >= 0 && done_cyc >= 0) break;
        end
    endtask

    // One handshake; latency and EN timing are counted in edges after the accept edge.
    task automatic write_one(input logic w_rs, input logic [7:0] w_data,
                             output int lat, output int en_first, output int en_len,
                             output logic [7:0] d0, output logic rs0, output logic rdy0);
        lat      = -1;
        en_first = -1;
        en_len   = 0;
        wait_ready();
        valid = 1'b1;
        rs    = w_rs;
        data  = w_data;
        tick();
        valid = 1'b0;
        d0    = lcd_data;
        rs0   = lcd_rs;
        rdy0  = ready;
        for (int n = 1; n <= 200; n++) begin
            tick();
            if (lcd_en) begin
                if (en_first < 0) en_first = n;
                en_len++;
            end
            if (ready) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        lcd_on_in = 1'b1;
        repeat (3) tick();
        checks++; if (lcd_en !== 1'b0) begin errors++; $display("FAIL reset_en: got %b want 0", lcd_en); end
        checks++; if (lcd_rs !== 1'b0) begin errors++; $display("FAIL reset_rs: got %b want 0", lcd_rs); end
        checks++; if (lcd_rw !== 1'b0) begin errors++; $display("FAIL reset_rw: got %b want 0", lcd_rw); end
        checks++; if (lcd_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", lcd_data); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready); end
        checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done: got %b want 0", init_done); end
        checks++; if (lcd_on !== 1'b0) begin errors++; $display("FAIL reset_lcd_on: got %b want 0", lcd_on); end
    endtask

    task automatic test_init();
        logic [7:0] exp_cmd [4];
        exp_cmd[0] = 8'h38;
        exp_cmd[1] = 8'h0C;
        exp_cmd[2] = 8'h01;
        exp_cmd[3] = 8'h06;
        run_init();
        checks++; if (npulse !== 4) begin errors++; $display("FAIL init_pulses: got %0d want 4", npulse); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (pd[i] !== exp_cmd[i]) begin errors++; $display("FAIL init_cmd%0d: got %h want %h", i, pd[i], exp_cmd[i]); end
            checks++;
            if (pw[i] !== 4) begin errors++; $display("FAIL init_width%0d: got %0d want 4", i, pw[i]); end
        end
        checks++; if (rs_bad !== 1'b0) begin errors++; $display("FAIL init_rs: rs high during EN, got %b want 0", rs_bad); end
        checks++; if (rw_bad !== 1'b0) begin errors++; $display("FAIL init_rw: got %b want 0", rw_bad); end
        checks++; if (rdy_cyc !== 112) begin errors++; $display("FAIL init_ready_cycle: got %0d want 112", rdy_cyc); end
        checks++; if (done_cyc !== 112) begin errors++; $display("FAIL init_done_cycle: got %0d want 112", done_cyc); end
    endtask

    task automatic test_data_write();
        int lat, en_first, en_len;
        logic [7:0] d0;
        logic rs0, rdy0;
        write_one(1'b1, 8'h41, lat, en_first, en_len, d0, rs0, rdy0);
        checks++; if (d0 !== 8'h41) begin errors++; $display("FAIL data_pins: got %h want 41", d0); end
        checks++; if (rs0 !== 1'b1) begin errors++; $display("FAIL data_rs: got %b want 1", rs0); end
        checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL data_ready_drop: got %b want 0", rdy0); end
        checks++; if (en_first !== 2) begin errors++; $display("FAIL data_en_start: got %0d want 2", en_first); end
        checks++; if (en_len !== 4) begin errors++; $display("FAIL data_en_len: got %0d want 4", en_len); end
        checks++; if (lat !== 18) begin errors++; $display("FAIL data_latency: got %0d want 18", lat); end
    endtask

    task automatic test_clear_timing();
        logic       v_rs  [4];
        logic [7:0] v_dat [4];
        int         v_lat [4];
        int lat, en_first, en_len;
        logic [7:0] d0;
        logic rs0, rdy0;
        v_rs[0] = 1'b0; v_dat[0] = 8'h01; v_lat[0] = 38;
        v_rs[1] = 1'b0; v_dat[1] = 8'h02; v_lat[1] = 38;
        v_rs[2] = 1'b1; v_dat[2] = 8'h01; v_lat[2] = 18;
        v_rs[3] = 1'b0; v_dat[3] = 8'h04; v_lat[3] = 18;
        for (int i = 0; i < 4; i++) begin
            write_one(v_rs[i], v_dat[i], lat, en_first, en_len, d0, rs0, rdy0);
            checks++;
            if (lat !== v_lat[i]) begin
                errors++;
                $display("FAIL clear_latency rs=%b data=%h: got %0d want %0d", v_rs[i], v_dat[i], lat, v_lat[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int bad;
        int lat2;
        wait_ready();
        valid = 1'b1;
        rs    = 1'b1;
        data  = 8'h48;
        tick();
        checks++; if (lcd_data !== 8'h48) begin errors++; $display("FAIL b2b_first_data: got %h want 48", lcd_data); end
        bad = 0;
        data = 8'h55;
        for (int n = 1; n <= 17; n++) begin
            tick();
            if (lcd_data !== 8'h48 || lcd_rs !== 1'b1) bad++;
            if (n == 17) data = 8'h49;
            else data = (n % 2 == 1) ? 8'h5A : 8'h55;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL b2b_pins_stable: %0d changed cycles, want 0", bad); end
        tick();
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_back: got %b want 1", ready); end
        checks++; if (lcd_data !== 8'h48) begin errors++; $display("FAIL b2b_data_before_accept: got %h want 48", lcd_data); end
        tick();
        valid = 1'b0;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL b2b_second_accept: ready got %b want 0", ready); end
        checks++; if (lcd_data !== 8'h49) begin errors++; $display("FAIL b2b_second_data: got %h want 49", lcd_data); end
        lat2 = -1;
        for (int n = 1; n <= 100; n++) begin
            tick();
            if (ready) begin
                lat2 = n;
                break;
            end
        end
        checks++; if (lat2 !== 18) begin errors++; $display("FAIL b2b_second_latency: got %0d want 18", lat2); end
    endtask

    task automatic test_lcd_on();
        int bad;
        int lat;
        logic applied;
        wait_ready();
        lcd_on_in = 1'b0;
        #1;
        checks++; if (lcd_on !== 1'b1) begin errors++; $display("FAIL lcd_on_latency_fall: got %b want 1", lcd_on); end
        tick();
        checks++; if (lcd_on !== 1'b0) begin errors++; $display("FAIL lcd_on_idle_0: got %b want 0", lcd_on); end
        lcd_on_in = 1'b1;
        #1;
        checks++; if (lcd_on !== 1'b0) begin errors++; $display("FAIL lcd_on_latency_rise: got %b want 0", lcd_on); end
        tick();
        checks++; if (lcd_on !== 1'b1) begin errors++; $display("FAIL lcd_on_idle_1: got %b want 1", lcd_on); end
        valid = 1'b1;
        rs    = 1'b1;
        data  = 8'h30;
        tick();
        valid = 1'b0;
        bad = 0;
        lat = -1;
        for (int n = 1; n <= 100; n++) begin
            applied   = (n % 3 == 0);
            lcd_on_in = applied;
            tick();
            if (lcd_on !== applied) bad++;
            if (ready) begin
                lat = n;
                break;
            end
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL lcd_on_busy_follow: %0d wrong cycles, want 0", bad); end
        checks++; if (lat !== 18) begin errors++; $display("FAIL lcd_on_write_latency: got %0d want 18", lat); end
        lcd_on_in = 1'b1;
    endtask

    task automatic test_reset_mid_pulse();
        wait_ready();
        valid = 1'b1;
        rs    = 1'b1;
        data  = 8'h41;
        tick();
        valid = 1'b0;
        repeat (3) tick();
        checks++; if (lcd_en !== 1'b1) begin errors++; $display("FAIL midpulse_en_high: got %b want 1", lcd_en); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (lcd_en !== 1'b0) begin errors++; $display("FAIL async_reset_en: got %b want 0", lcd_en); end
        checks++; if (lcd_rs !== 1'b0) begin errors++; $display("FAIL async_reset_rs: got %b want 0", lcd_rs); end
        checks++; if (lcd_data !== 8'h00) begin errors++; $display("FAIL async_reset_data: got %h want 00", lcd_data); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL async_reset_ready: got %b want 0", ready); end
        checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL async_reset_init_done: got %b want 0", init_done); end
        checks++; if (lcd_on !== 1'b0) begin errors++; $display("FAIL async_reset_lcd_on: got %b want 0", lcd_on); end
        repeat (2) tick();
        run_init();
        checks++; if (npulse !== 4) begin errors++; $display("FAIL reinit_pulses: got %0d want 4", npulse); end
        checks++; if (pd[3] !== 8'h06) begin errors++; $display("FAIL reinit_last_cmd: got %h want 06", pd[3]); end
        checks++; if (rdy_cyc !== 112) begin errors++; $display("FAIL reinit_ready_cycle: got %0d want 112", rdy_cyc); end
        checks++; if (done_cyc !== 112) begin errors++; $display("FAIL reinit_done_cycle: got %0d want 112", done_cyc); end
    endtask

    initial begin
        reset_n   = 1'b0;
        valid     = 1'b0;
        rs        = 1'b0;
        data      = 8'h00;
        lcd_on_in = 1'b0;
        test_reset();
        test_init();
        test_data_write();
        test_clear_timing();
        test_back_to_back();
        test_lcd_on();
        test_reset_mid_pulse();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
